cgol_gen_sequencer: RTL and testbench

Sequences the combinational Life-rule `decoder` (center + 8 neighbours → `nexton`) across a toroidal board to compute whole generations. Holds a double-buffered board and evaluates one cell per clock through a single shared `decoder` instance. Runs a requested number of generations, stopping early on a still life. Sits between the board loader/host and the display readout.

---
 rtl/cgol_pkg.sv | 31 +++
 rtl/decoder.sv | 19 +
 rtl/cgol_gen_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cgol_gen_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgol_pkg.sv
// Shared types and helpers for the Life generation sequencer.
package cgol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit positions inside the decoder's 8-bit neighbour vector.
    localparam int NB_NW = 7;
    localparam int NB_N  = 6;
    localparam int NB_NE = 5;
    localparam int NB_W  = 4;
    localparam int NB_E  = 3;
    localparam int NB_SW = 2;
    localparam int NB_S  = 1;
    localparam int NB_SE = 0;

    // Toroidal predecessor of idx in 0..n-1.
    function automatic int wrap_dec(input int idx, input int n);
        return (idx == 0) ? n - 1 : idx - 1;
    endfunction

    // Toroidal successor of idx in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/decoder.sv
// Conway Life rule for a single cell: birth on 3, survival on 2 or 3.
module decoder (
    input  logic       center,
    input  logic [7:0] sides,
    output logic       nexton
);

    logic [3:0] cnt;

    // Count live neighbours and apply the B3/S23 rule.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(sides[i]);
        end
        nexton = (cnt == 4'd3) || (center && (cnt == 4'd2));
    end

endmodule

// File: rtl/cgol_gen_sequencer.sv
// Runs whole Life generations on a toroidal W x H board, one cell per clock,
// using a single shared decoder and a double-buffered board.
module cgol_gen_sequencer
    import cgol_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [$clog2(H)-1:0]         load_row,
    input  logic [W-1:0]                 load_data,
    input  logic                         start,
    input  logic [15:0]                  gens,
    input  logic [$clog2(H)-1:0]         rd_row,
    output logic [W-1:0]                 rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         stable,
    output logic [15:0]                  gen_count,
    output logic [$clog2(W*H+1)-1:0]     population
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    localparam int PW = $clog2(W*H+1);

    state_t                state_q, state_d;
    logic [H-1:0][W-1:0]   cur_q, cur_d;
    logic [H-1:0][W-1:0]   nxt_q, nxt_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [15:0]           rem_q, rem_d;
    logic [15:0]           gen_q, gen_d;
    logic [PW-1:0]         live_q, live_d;
    logic [PW-1:0]         pop_q, pop_d;
    logic                  chg_q, chg_d;
    logic                  stable_q, stable_d;

    logic [RW-1:0]         row_n, row_s;
    logic [CW-1:0]         col_w, col_e;
    logic [W-1:0]          line_n, line_m, line_s;
    logic                  center;
    logic [7:0]            sides;
    logic                  nexton;

    // Gather the 3x3 neighbourhood of the current cell with toroidal wrap.
    always_comb begin
        row_n  = RW'(wrap_dec(int'(row_q), H));
        row_s  = RW'(wrap_inc(int'(row_q), H));
        col_w  = CW'(wrap_dec(int'(col_q), W));
        col_e  = CW'(wrap_inc(int'(col_q), W));
        line_n = cur_q[row_n];
        line_m = cur_q[row_q];
        line_s = cur_q[row_s];
        center = line_m[col_q];
        sides        = 8'd0;
        sides[NB_NW] = line_n[col_w];
        sides[NB_N]  = line_n[col_q];
        sides[NB_NE] = line_n[col_e];
        sides[NB_W]  = line_m[col_w];
        sides[NB_E]  = line_m[col_e];
        sides[NB_SW] = line_s[col_w];
        sides[NB_S]  = line_s[col_q];
        sides[NB_SE] = line_s[col_e];
    end

    decoder u_decoder (
        .center (center),
        .sides  (sides),
        .nexton (nexton)
    );

    // Next-state logic: FSM, scan pointer, counters and board banks.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        row_d    = row_q;
        col_d    = col_q;
        rem_d    = rem_q;
        gen_d    = gen_q;
        live_d   = live_q;
        pop_d    = pop_q;
        chg_d    = chg_q;
        stable_d = stable_q;
        case (state_q)
            IDLE: begin
                // Load lands in cur before the first SCAN cycle reads it.
                if (load_en && (int'(load_row) < H)) begin
                    cur_d[load_row] = load_data;
                end
                if (start) begin
                    stable_d = 1'b0;
                    if (gens != 16'd0) begin
                        rem_d   = gens;
                        row_d   = '0;
                        col_d   = '0;
                        live_d  = '0;
                        chg_d   = 1'b0;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                nxt_d[row_q][col_q] = nexton;
                live_d = live_q + PW'(nexton);
                chg_d  = chg_q | (nexton ^ center);
                if (col_q == CW'(W - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(H - 1)) begin
                        state_d = SWAP;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            SWAP: begin
                // Whole-board commit keeps readout free of half-updated boards.
                cur_d  = nxt_q;
                pop_d  = live_q;
                gen_d  = gen_q + 16'd1;
                rem_d  = rem_q - 16'd1;
                row_d  = '0;
                col_d  = '0;
                live_d = '0;
                chg_d  = 1'b0;
                if (!chg_q) begin
                    stable_d = 1'b1;
                    state_d  = DONE;
                end else if (rem_q == 16'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            nxt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rem_q    <= '0;
            gen_q    <= '0;
            live_q   <= '0;
            pop_q    <= '0;
            chg_q    <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rem_q    <= rem_d;
            gen_q    <= gen_d;
            live_q   <= live_d;
            pop_q    <= pop_d;
            chg_q    <= chg_d;
            stable_q <= stable_d;
        end
    end

    assign rd_data    = (int'(rd_row) < H) ? cur_q[rd_row] : '0;
    assign busy       = (state_q == SCAN) || (state_q == SWAP);
    assign done       = (state_q == DONE);
    assign stable     = stable_q;
    assign gen_count  = gen_q;
    assign population = pop_q;

endmodule

// File: tb/tb_cgol_gen_sequencer.sv
// Self-checking bench: directed table, hand-written corner sequences and
// random boards checked against a plain-arithmetic Life model.
module tb_cgol_gen_sequencer;

    localparam int W = 8;
    localparam int H = 8;
    localparam int GEN_CYC = W * H + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_row = 3'd0;
    logic [7:0]  load_data = 8'd0;
    logic        start = 1'b0;
    logic [15:0] gens = 16'd0;
    logic [2:0]  rd_row = 3'd0;
    logic [7:0]  rd_data;
    logic        busy, done, stable;
    logic [15:0] gen_count;
    logic [6:0]  population;

    int n_vec = 0;
    int n_err = 0;

    cgol_gen_sequencer #(.W(W), .H(H)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .start(start), .gens(gens), .rd_row(rd_row),
        .rd_data(rd_data), .busy(busy), .done(done), .stable(stable),
        .gen_count(gen_count), .population(population)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] init_b;
        int          g;
        logic [63:0] exp_b;
        int          exp_pop;
        int          exp_n;
        bit          exp_st;
    } vec_t;

    vec_t vt[7];

    function automatic logic [63:0] brd(input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7);
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; load_en = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_board(input logic [63:0] b);
        for (int r = 0; r < H; r++) begin
            @(negedge clk);
            load_en = 1'b1; load_row = 3'(r); load_data = b[r*8 +: 8];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic read_board(output logic [63:0] b);
        b = '0;
        for (int r = 0; r < H; r++) begin
            rd_row = 3'(r);
            #1;
            b[r*8 +: 8] = rd_data;
        end
    endtask

    // Start a run (optionally loading a row in the same cycle) and wait for done.
    task automatic run_gen(input int g, input bit ld, input int ld_row, input logic [7:0] ld_data,
                           output int lat, output bit saw_busy, output bit done_after);
        @(negedge clk);
        start = 1'b1; gens = 16'(g);
        load_en = ld; load_row = 3'(ld_row); load_data = ld_data;
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        lat = -1; saw_busy = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            if (busy) saw_busy = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
    endtask

    // Reference: apply B3/S23 on a torus with modular indexing, stop early when unchanged.
    task automatic model_run(input logic [63:0] init_b, input int g, output logic [63:0] fin,
                             output int n, output bit st, output int pop);
        bit mb[H][W];
        bit nb[H][W];
        bit ch;
        int cnt;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                mb[r][c] = init_b[r*W + c];
        n = 0; st = 1'b0;
        while (n < g) begin
            ch = 1'b0;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    cnt = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (dr != 0 || dc != 0)
                                cnt += int'(mb[(r + dr + H) % H][(c + dc + W) % W]);
                    nb[r][c] = (cnt == 3) || (mb[r][c] && cnt == 2);
                    if (nb[r][c] != mb[r][c]) ch = 1'b1;
                end
            end
            mb = nb;
            n++;
            if (!ch) begin
                st = 1'b1;
                break;
            end
        end
        fin = '0; pop = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fin[r*W + c] = mb[r][c];
                pop += int'(mb[r][c]);
            end
    endtask

    initial begin
        logic [63:0] b, fin;
        int lat, n, pop;
        bit sb, da, st;

        vt[0] = '{"blinker1", brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00), 1,
                  brd(8'h00,8'h00,8'h08,8'h08,8'h08,8'h00,8'h00,8'h00), 3, 1, 1'b0};
        vt[1] = '{"blinker2", brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00), 2,
                  brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00), 3, 2, 1'b0};
        vt[2] = '{"glider32", brd(8'h02,8'h04,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00), 32,
                  brd(8'h02,8'h04,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00), 5, 32, 1'b0};
        vt[3] = '{"wrapblock", brd(8'h81,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h81), 10,
                  brd(8'h81,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h81), 4, 1, 1'b1};
        vt[4] = '{"gens0", brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00), 0,
                  brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00), 0, 0, 1'b0};
        vt[5] = '{"empty", 64'h0, 5, 64'h0, 0, 1, 1'b1};
        vt[6] = '{"lonecell", brd(8'h00,8'h00,8'h00,8'h00,8'h10,8'h00,8'h00,8'h00), 3,
                  64'h0, 0, 2, 1'b1};

        // Reset state
        do_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_pop", 64'(population), 64'd0);
        read_board(b);
        chk("rst_board", b, 64'h0);

        // Load latency: row visible the cycle after load_en
        @(negedge clk);
        load_en = 1'b1; load_row = 3'd5; load_data = 8'hA5;
        @(negedge clk);
        load_en = 1'b0; rd_row = 3'd5;
        #1;
        chk("load_latency", 64'(rd_data), 64'hA5);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            load_board(vt[i].init_b);
            run_gen(vt[i].g, 1'b0, 0, 8'h00, lat, sb, da);
            chk({vt[i].name, "_lat"}, 64'(lat), 64'(1 + vt[i].exp_n * GEN_CYC));
            chk({vt[i].name, "_pulse"}, 64'(da), 64'd0);
            chk({vt[i].name, "_busy"}, 64'(sb), 64'(vt[i].exp_n > 0));
            read_board(b);
            chk({vt[i].name, "_board"}, b, vt[i].exp_b);
            chk({vt[i].name, "_pop"}, 64'(population), 64'(vt[i].exp_pop));
            chk({vt[i].name, "_gen"}, 64'(gen_count), 64'(vt[i].exp_n));
            chk({vt[i].name, "_stable"}, 64'(stable), 64'(vt[i].exp_st));
        end

        // Load and start in the same cycle, then a second run accumulating gen_count
        do_reset();
        run_gen(1, 1'b1, 3, 8'h1C, lat, sb, da);
        chk("ldstart_lat", 64'(lat), 64'(1 + GEN_CYC));
        read_board(b);
        chk("ldstart_board", b, brd(8'h00,8'h00,8'h08,8'h08,8'h08,8'h00,8'h00,8'h00));
        run_gen(2, 1'b0, 0, 8'h00, lat, sb, da);
        chk("accum_lat", 64'(lat), 64'(1 + 2 * GEN_CYC));
        chk("accum_gen", 64'(gen_count), 64'd3);
        read_board(b);
        chk("accum_board", b, brd(8'h00,8'h00,8'h08,8'h08,8'h08,8'h00,8'h00,8'h00));

        // start/load_en pulsed while busy must be ignored
        do_reset();
        load_board(brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00));
        @(negedge clk);
        start = 1'b1; gens = 16'd3;
        @(negedge clk);
        start = 1'b0; lat = -1; rd_row = 3'd0;
        for (int k = 1; k <= 5000; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k == 10 || k == 100) begin
                start = 1'b1; gens = 16'd7; load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF;
            end else begin
                start = 1'b0; load_en = 1'b0;
            end
            if (k == 12) chk("ign_row0_intact", 64'(rd_data), 64'h0);
            @(negedge clk);
        end
        start = 1'b0; load_en = 1'b0;
        chk("ign_lat", 64'(lat), 64'(1 + 3 * GEN_CYC));
        @(negedge clk);
        chk("ign_no_restart", 64'(busy), 64'd0);
        read_board(b);
        chk("ign_board", b, brd(8'h00,8'h00,8'h08,8'h08,8'h08,8'h00,8'h00,8'h00));
        chk("ign_gen", 64'(gen_count), 64'd3);
        chk("ign_pop", 64'(population), 64'd3);

        // Reset in the middle of the second generation's scan
        do_reset();
        load_board(brd(8'h00,8'h00,8'h00,8'h1C,8'h00,8'h00,8'h00,8'h00));
        @(negedge clk);
        start = 1'b1; gens = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        chk("mid_gen_before", 64'(gen_count), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_gen", 64'(gen_count), 64'd0);
        chk("mid_rst_pop", 64'(population), 64'd0);
        read_board(b);
        chk("mid_rst_board", b, 64'h0);
        reset = 1'b0;
        sb = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy) sb = 1'b1;
        end
        chk("mid_rst_quiet", 64'(sb), 64'd0);

        // Random boards against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [63:0] rb;
            int g;
            rb = {32'($urandom), 32'($urandom)};
            if (i >= 4) rb = rb & {32'($urandom), 32'($urandom)};
            g = int'($urandom_range(1, 6));
            model_run(rb, g, fin, n, st, pop);
            do_reset();
            load_board(rb);
            run_gen(g, 1'b0, 0, 8'h00, lat, sb, da);
            chk("rnd_lat", 64'(lat), 64'(1 + n * GEN_CYC));
            read_board(b);
            chk("rnd_board", b, fin);
            chk("rnd_pop", 64'(population), 64'(pop));
            chk("rnd_gen", 64'(gen_count), 64'(n));
            chk("rnd_stable", 64'(stable), 64'(st));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
